// File: rtl/l1_instruction_cache_pkg.sv
// Shared defines (controller data-source codes, cache FSM encodings) and the
// package of types imported by the instruction-cache files.
`ifndef L1I_SHARED_DEFINES
`define L1I_SHARED_DEFINES
`define DATA_SOURCE_NONE 2'b00
`define DATA_SOURCE_ROM  2'b01
`define DATA_SOURCE_RAM  2'b10
`define DATA_SOURCE_PER  2'b11
`define L1I_STATE_IDLE    2'd0
`define L1I_STATE_REQUEST 2'd1
`define L1I_STATE_WAIT    2'd2
`endif

package l1_instruction_cache_pkg;

  localparam int WORD_BITS = 32;

  typedef enum logic [1:0] {
    L1I_IDLE    = `L1I_STATE_IDLE,
    L1I_REQUEST = `L1I_STATE_REQUEST,
    L1I_WAIT    = `L1I_STATE_WAIT
  } l1i_state_e;

endpackage

// File: rtl/l1i_line_store.sv
// Direct-mapped line array: async read, one sync write port for
// {valid, tag, data} and a bulk clear of every valid bit.
module l1i_line_store
  import l1_instruction_cache_pkg::*;
#(
  parameter int NUM_LINES  = 16,
  parameter int INDEX_BITS = $clog2(NUM_LINES),
  parameter int TAG_BITS   = 30 - INDEX_BITS
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  write,
  input  logic [INDEX_BITS-1:0] write_index,
  input  logic [TAG_BITS-1:0]   write_tag,
  input  logic [WORD_BITS-1:0]  write_data,
  input  logic [INDEX_BITS-1:0] read_index,
  output logic                  read_valid,
  output logic [TAG_BITS-1:0]   read_tag,
  output logic [WORD_BITS-1:0]  read_data
);

  logic [NUM_LINES-1:0] valid;
  logic [TAG_BITS-1:0]  tag_mem  [NUM_LINES];
  logic [WORD_BITS-1:0] data_mem [NUM_LINES];

  // Clear beats a same-cycle write so a flush can never leave a fresh line valid.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      valid <= '0;
    end else if (write) begin
      valid[write_index] <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (write) begin
      tag_mem[write_index]  <= write_tag;
      data_mem[write_index] <= write_data;
    end
  end

  assign read_valid = valid[read_index];
  assign read_tag   = tag_mem[read_index];
  assign read_data  = data_mem[read_index];

endmodule

// File: rtl/l1_instruction_cache.sv
// Direct-mapped, one-word-per-line instruction cache: same-cycle hits, and a
// miss FSM that reads the ROM through the memory controller's instruction port.
module l1_instruction_cache
  import l1_instruction_cache_pkg::*;
#(
  parameter  int NUM_LINES  = 16,
  localparam int INDEX_BITS = $clog2(NUM_LINES)
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] cpu_address,
  input  logic        cpu_read,
  input  logic        flush,
  output logic [31:0] cpu_data,
  output logic        cpu_ready,
  output logic        stall_cpu,
  output logic [31:0] mem_address,
  output logic        mem_read,
  input  logic        mem_stall,
  input  logic [31:0] mem_data,
  input  logic [1:0]  mem_data_source,
  output logic [1:0]  state
);

  localparam int TAG_BITS = 30 - INDEX_BITS;

  l1i_state_e            state_q;
  logic [29:0]           miss_addr;
  logic [INDEX_BITS-1:0] index;
  logic [TAG_BITS-1:0]   tag;
  logic                  line_valid;
  logic [TAG_BITS-1:0]   line_tag;
  logic [31:0]           line_data;
  logic                  hit;
  logic                  miss;
  logic                  fill;
  logic                  unused_addr_bits;

  assign index = cpu_address[INDEX_BITS+1:2];
  assign tag   = cpu_address[31:INDEX_BITS+2];
  assign unused_addr_bits = ^cpu_address[1:0];

  // Lookups only count in IDLE; flush and reset suppress the hit that cycle.
  assign hit  = !reset && !flush && (state_q == L1I_IDLE) && cpu_read &&
                line_valid && (line_tag == tag);
  assign miss = (state_q == L1I_IDLE) && cpu_read && !hit;
  assign fill = !reset && !flush && (state_q == L1I_WAIT) && !mem_stall &&
                (mem_data_source == `DATA_SOURCE_ROM);

  assign cpu_ready   = hit;
  assign cpu_data    = hit ? line_data : 32'h0;
  assign stall_cpu   = !reset && (flush || (state_q != L1I_IDLE) || miss);
  assign mem_address = {miss_addr, 2'b00};
  assign state       = state_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= L1I_IDLE;
      mem_read  <= 1'b0;
      miss_addr <= '0;
    end else if (flush) begin
      state_q  <= L1I_IDLE;
      mem_read <= 1'b0;
    end else begin
      case (state_q)
        L1I_IDLE: begin
          if (miss) begin
            miss_addr <= cpu_address[31:2];
            mem_read  <= 1'b1;
            state_q   <= L1I_REQUEST;
          end
        end
        L1I_REQUEST: begin
          if (!mem_stall) state_q <= L1I_WAIT;
        end
        // A data-side access may own the controller output; keep asking.
        L1I_WAIT: begin
          if (fill) begin
            mem_read <= 1'b0;
            state_q  <= L1I_IDLE;
          end
        end
        default: begin
          mem_read <= 1'b0;
          state_q  <= L1I_IDLE;
        end
      endcase
    end
  end

  l1i_line_store #(
    .NUM_LINES (NUM_LINES),
    .INDEX_BITS(INDEX_BITS),
    .TAG_BITS  (TAG_BITS)
  ) u_line_store (
    .clock      (clock),
    .reset      (reset),
    .clear      (flush),
    .write      (fill),
    .write_index(miss_addr[INDEX_BITS-1:0]),
    .write_tag  (miss_addr[29:INDEX_BITS]),
    .write_data (mem_data),
    .read_index (index),
    .read_valid (line_valid),
    .read_tag   (line_tag),
    .read_data  (line_data)
  );

endmodule

// File: tb/tb_l1_instruction_cache.sv
// Directed bench for l1_instruction_cache: a vector table for miss/hit and
// conflict sequences plus hand-written multi-cycle corner cases.
`ifndef L1I_SHARED_DEFINES
`define L1I_SHARED_DEFINES
`define DATA_SOURCE_NONE 2'b00
`define DATA_SOURCE_ROM  2'b01
`define DATA_SOURCE_RAM  2'b10
`define DATA_SOURCE_PER  2'b11
`define L1I_STATE_IDLE    2'd0
`define L1I_STATE_REQUEST 2'd1
`define L1I_STATE_WAIT    2'd2
`endif

module tb_l1_instruction_cache;

  logic        clock;
  logic        reset;
  logic [31:0] cpu_address;
  logic        cpu_read;
  logic        flush;
  logic [31:0] cpu_data;
  logic        cpu_ready;
  logic        stall_cpu;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_stall;
  logic [31:0] mem_data;
  logic [1:0]  mem_data_source;
  logic [1:0]  state;

  logic [31:0] rom [64];
  logic        force_en;
  logic [31:0] force_data;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        rd;
    logic [31:0] addr;
    logic        fl;
    logic        ready;
    logic        stall;
    logic        mread;
    logic [31:0] data;
  } vec_t;

  vec_t vecs[$];

  l1_instruction_cache #(.NUM_LINES(16)) dut (
    .clock          (clock),
    .reset          (reset),
    .cpu_address    (cpu_address),
    .cpu_read       (cpu_read),
    .flush          (flush),
    .cpu_data       (cpu_data),
    .cpu_ready      (cpu_ready),
    .stall_cpu      (stall_cpu),
    .mem_address    (mem_address),
    .mem_read       (mem_read),
    .mem_stall      (mem_stall),
    .mem_data       (mem_data),
    .mem_data_source(mem_data_source),
    .state          (state)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ROM side of the controller; the address is stable across WAIT
  assign mem_data = force_en ? force_data : rom[mem_address[7:2]];

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(logic rd, logic [31:0] addr, logic fl, logic ready,
                               logic stall, logic mread, logic [31:0] data);
    vec_t v;
    v.rd = rd; v.addr = addr; v.fl = fl; v.ready = ready;
    v.stall = stall; v.mread = mread; v.data = data;
    return v;
  endfunction

  // Plain miss from IDLE through to the replayed hit
  task automatic fill_and_hit(input logic [31:0] addr, input logic [31:0] exp);
    cpu_read = 1'b1; cpu_address = addr;
    #1 check("fill_miss_stall", {31'b0, stall_cpu}, 32'd1);
    cyc();
    #1 check("fill_req_mem_read", {31'b0, mem_read}, 32'd1);
    check("fill_req_address", mem_address, addr);
    cyc();
    #1 check("fill_wait_state", {30'b0, state}, {30'b0, `L1I_STATE_WAIT});
    cyc();
    #1 check("fill_hit_ready", {31'b0, cpu_ready}, 32'd1);
    check("fill_hit_data", cpu_data, exp);
    check("fill_hit_stall", {31'b0, stall_cpu}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 32'hA5A5_0000 | i;
    rom[4] = 32'h0050_0093;
    rom[3] = 32'h0000_0013;
    force_en = 1'b0; force_data = '0;
    reset = 1'b1; cpu_read = 1'b0; cpu_address = '0; flush = 1'b0;
    mem_stall = 1'b0; mem_data_source = `DATA_SOURCE_ROM;
    cyc(); cyc();
    reset = 1'b0;
    #1;
    check("reset_cpu_ready", {31'b0, cpu_ready}, 32'd0);
    check("reset_stall_cpu", {31'b0, stall_cpu}, 32'd0);
    check("reset_mem_read", {31'b0, mem_read}, 32'd0);
    check("reset_mem_address", mem_address, 32'h0);
    check("reset_cpu_data", cpu_data, 32'h0);
    check("reset_state", {30'b0, state}, {30'b0, `L1I_STATE_IDLE});
    cyc();

    // Cold miss/hit at 0x10, then conflict eviction on index 1
    vecs.push_back(mkv(1, 32'h10, 0, 0, 1, 0, 32'h0));
    vecs.push_back(mkv(1, 32'h10, 0, 0, 1, 1, 32'h0));
    vecs.push_back(mkv(1, 32'h10, 0, 0, 1, 1, 32'h0));
    vecs.push_back(mkv(1, 32'h10, 0, 1, 0, 0, 32'h0050_0093));
    vecs.push_back(mkv(1, 32'h10, 0, 1, 0, 0, 32'h0050_0093));
    vecs.push_back(mkv(0, 32'h10, 0, 0, 0, 0, 32'h0));
    vecs.push_back(mkv(1, 32'h04, 0, 0, 1, 0, 32'h0));
    vecs.push_back(mkv(1, 32'h04, 0, 0, 1, 1, 32'h0));
    vecs.push_back(mkv(1, 32'h04, 0, 0, 1, 1, 32'h0));
    vecs.push_back(mkv(1, 32'h04, 0, 1, 0, 0, 32'hA5A5_0001));
    vecs.push_back(mkv(1, 32'h44, 0, 0, 1, 0, 32'h0));
    vecs.push_back(mkv(1, 32'h44, 0, 0, 1, 1, 32'h0));
    vecs.push_back(mkv(1, 32'h44, 0, 0, 1, 1, 32'h0));
    vecs.push_back(mkv(1, 32'h44, 0, 1, 0, 0, 32'hA5A5_0011));
    vecs.push_back(mkv(1, 32'h04, 0, 0, 1, 0, 32'h0));
    vecs.push_back(mkv(1, 32'h04, 0, 0, 1, 1, 32'h0));
    vecs.push_back(mkv(1, 32'h04, 0, 0, 1, 1, 32'h0));
    vecs.push_back(mkv(1, 32'h04, 0, 1, 0, 0, 32'hA5A5_0001));
    vecs.push_back(mkv(1, 32'h10, 0, 1, 0, 0, 32'h0050_0093));

    for (int i = 0; i < vecs.size(); i++) begin
      cpu_read = vecs[i].rd; cpu_address = vecs[i].addr; flush = vecs[i].fl;
      #1;
      check($sformatf("vec%0d_cpu_ready", i), {31'b0, cpu_ready}, {31'b0, vecs[i].ready});
      check($sformatf("vec%0d_stall_cpu", i), {31'b0, stall_cpu}, {31'b0, vecs[i].stall});
      check($sformatf("vec%0d_mem_read", i), {31'b0, mem_read}, {31'b0, vecs[i].mread});
      check($sformatf("vec%0d_cpu_data", i), cpu_data, vecs[i].data);
      if (vecs[i].mread)
        check($sformatf("vec%0d_mem_address", i), mem_address, vecs[i].addr);
      cyc();
    end

    // Controller stall held for two REQUEST cycles: five stall cycles total
    cpu_read = 1'b1; cpu_address = 32'h20;
    #1 check("cstall_c1_stall", {31'b0, stall_cpu}, 32'd1);
    cyc();
    mem_stall = 1'b1;
    #1 check("cstall_c2_state", {30'b0, state}, {30'b0, `L1I_STATE_REQUEST});
    check("cstall_c2_mem_read", {31'b0, mem_read}, 32'd1);
    check("cstall_c2_stall", {31'b0, stall_cpu}, 32'd1);
    cyc();
    #1 check("cstall_c3_state", {30'b0, state}, {30'b0, `L1I_STATE_REQUEST});
    check("cstall_c3_mem_read", {31'b0, mem_read}, 32'd1);
    check("cstall_c3_stall", {31'b0, stall_cpu}, 32'd1);
    cyc();
    mem_stall = 1'b0;
    #1 check("cstall_c4_state", {30'b0, state}, {30'b0, `L1I_STATE_REQUEST});
    check("cstall_c4_stall", {31'b0, stall_cpu}, 32'd1);
    cyc();
    #1 check("cstall_c5_state", {30'b0, state}, {30'b0, `L1I_STATE_WAIT});
    check("cstall_c5_mem_read", {31'b0, mem_read}, 32'd1);
    check("cstall_c5_stall", {31'b0, stall_cpu}, 32'd1);
    cyc();
    #1 check("cstall_c6_ready", {31'b0, cpu_ready}, 32'd1);
    check("cstall_c6_data", cpu_data, 32'hA5A5_0008);

    // Data-side owns the output mux for one WAIT cycle
    cyc();
    cpu_address = 32'h0C;
    #1 check("wsrc_miss_stall", {31'b0, stall_cpu}, 32'd1);
    cyc(); cyc();
    mem_data_source = `DATA_SOURCE_RAM; force_en = 1'b1; force_data = 32'hDEAD_BEEF;
    #1 check("wsrc_ram_state", {30'b0, state}, {30'b0, `L1I_STATE_WAIT});
    check("wsrc_ram_ready", {31'b0, cpu_ready}, 32'd0);
    check("wsrc_ram_data", cpu_data, 32'h0);
    cyc();
    #1 check("wsrc_still_wait", {30'b0, state}, {30'b0, `L1I_STATE_WAIT});
    check("wsrc_still_mem_read", {31'b0, mem_read}, 32'd1);
    mem_data_source = `DATA_SOURCE_ROM; force_data = 32'h0000_0013;
    cyc();
    force_en = 1'b0;
    #1 check("wsrc_hit_ready", {31'b0, cpu_ready}, 32'd1);
    check("wsrc_hit_data", cpu_data, 32'h0000_0013);
    cyc();

    // Flush after a fill: re-fetch misses
    fill_and_hit(32'h08, 32'hA5A5_0002);
    cyc();
    flush = 1'b1;
    #1 check("flush_cycle_ready", {31'b0, cpu_ready}, 32'd0);
    check("flush_cycle_stall", {31'b0, stall_cpu}, 32'd1);
    cyc();
    flush = 1'b0;
    #1 check("flush_refetch_ready", {31'b0, cpu_ready}, 32'd0);
    check("flush_refetch_stall", {31'b0, stall_cpu}, 32'd1);
    check("flush_refetch_state", {30'b0, state}, {30'b0, `L1I_STATE_IDLE});
    cyc(); cyc(); cyc();
    #1 check("flush_refill_data", cpu_data, 32'hA5A5_0002);
    cyc();

    // Flush during WAIT aborts the fill
    cpu_address = 32'h18;
    cyc(); cyc();
    flush = 1'b1;
    #1 check("wflush_state", {30'b0, state}, {30'b0, `L1I_STATE_WAIT});
    check("wflush_ready", {31'b0, cpu_ready}, 32'd0);
    cyc();
    flush = 1'b0;
    #1 check("wflush_idle", {30'b0, state}, {30'b0, `L1I_STATE_IDLE});
    check("wflush_mem_read", {31'b0, mem_read}, 32'd0);
    check("wflush_remiss_ready", {31'b0, cpu_ready}, 32'd0);
    check("wflush_remiss_stall", {31'b0, stall_cpu}, 32'd1);
    cyc(); cyc(); cyc();
    #1 check("wflush_refill_data", cpu_data, 32'hA5A5_0006);
    cyc();

    // Reset in WAIT wipes every line and the pending miss
    fill_and_hit(32'h10, 32'h0050_0093);
    cyc();
    cpu_address = 32'h28;
    cyc(); cyc();
    #1 check("rmid_in_wait", {30'b0, state}, {30'b0, `L1I_STATE_WAIT});
    reset = 1'b1;
    cyc();
    reset = 1'b0; cpu_read = 1'b0;
    #1 check("rmid_mem_read", {31'b0, mem_read}, 32'd0);
    check("rmid_stall", {31'b0, stall_cpu}, 32'd0);
    check("rmid_state", {30'b0, state}, {30'b0, `L1I_STATE_IDLE});
    cpu_read = 1'b1; cpu_address = 32'h10;
    #1 check("rmid_old_hit_ready", {31'b0, cpu_ready}, 32'd0);
    check("rmid_old_hit_stall", {31'b0, stall_cpu}, 32'd1);
    cyc(); cyc(); cyc();
    #1 check("rmid_refill_data", cpu_data, 32'h0050_0093);
    cyc();
    cpu_read = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/l1_instruction_cache.md
Name: l1_instruction_cache

Overview:
Direct-mapped, one-word-per-line instruction cache between the fetch stage and the memory controller's instruction port. A hit returns the instruction in the same cycle. A miss stalls fetch, issues a ROM read through the controller, and waits out any controller stall caused by concurrent data-side traffic. It captures the word only when the controller reports the ROM as data source, then fills the line and replays the lookup.

Parameters:
NUM_LINES, 16, number of lines; power of two, 2..256
INDEX_BITS, $clog2(NUM_LINES), index width (derived, not overridden)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
cpu_address  input  32  fetch byte address; bits [1:0] ignored
cpu_read  input  1  fetch request this cycle
flush  input  1  invalidate all lines (fence.i)
cpu_data  output  32  instruction word, valid when cpu_ready=1
cpu_ready  output  1  hit; cpu_data valid this cycle
stall_cpu  output  1  fetch must hold cpu_address and cpu_read
mem_address  output  32  word-aligned address to controller instruction port
mem_read  output  1  instruction read request to controller
mem_stall  input  1  controller instruction-port stall
mem_data  input  32  controller output data
mem_data_source  input  2  controller data source (`DATA_SOURCE_*)

Behaviour:
- Reset (sync, active-high): all valid bits 0, state IDLE, mem_read=0, mem_address=0, cpu_ready=0, stall_cpu=0, cpu_data=0. Reset has priority over every other input, including mid-miss.
- Address split: index = cpu_address[INDEX_BITS+1:2], tag = cpu_address[31:INDEX_BITS+2]. Storage holds 32-bit data, a tag of width 30-INDEX_BITS, and a valid bit per line.
- Hit path is combinational and applies in IDLE only:
  - hit = cpu_read & valid[index] & (tag match).
  - On hit: cpu_ready=1, cpu_data=line data, stall_cpu=0.
  - When cpu_ready=0, cpu_data=0.
- Miss in IDLE (cpu_read & !hit):
  - stall_cpu=1 combinationally.
  - Latch miss_addr = {cpu_address[31:2],2'b00}.
  - Next state is REQUEST.
- REQUEST:
  - mem_read=1, mem_address=miss_addr, stall_cpu=1.
  - mem_stall=1: stay in REQUEST.
  - Otherwise go to WAIT.
- WAIT: the ROM read is registered, so data appears one cycle after the address is accepted.
  - mem_read=1, mem_address=miss_addr, stall_cpu=1.
  - If mem_stall=0 and mem_data_source==`DATA_SOURCE_ROM: write mem_data to the line, write the tag, set valid, go to IDLE.
  - Otherwise stay in WAIT. A data-side access has taken the output mux; mem_read stays asserted.
- IDLE after fill: the lookup replays and hits.
- Minimum miss penalty is 3 stall cycles: miss cycle, REQUEST, WAIT. cpu_ready=1 on the 4th cycle.
- cpu_read=0 in IDLE: cpu_ready=0, stall_cpu=0, no state change.
- cpu_address changes while stall_cpu=1 are a protocol violation. The fill always uses miss_addr.
- flush:
  - Clears all valid bits at the clock edge.
  - In REQUEST or WAIT it aborts the fill (no line written) and returns to IDLE.
  - In the flush cycle itself, cpu_ready=0 and stall_cpu=1.
- Line conflict: a fill overwrites the indexed line regardless of its previous valid/tag.
- mem_read=0 in IDLE; no speculative fetch.

Decomposition:
- The shared defines file already supplies `DATA_SOURCE_ROM/RAM/PER/NONE`.
- Add state encodings `L1I_STATE_IDLE`, `L1I_STATE_REQUEST` and `L1I_STATE_WAIT` to the same shared defines file.
- One sub-module is natural: l1i_line_store. It is a NUM_LINES-entry register array with async read and a sync write port for {valid, tag, data}, plus a bulk valid clear.
- The FSM and hit logic stay in the top module.

Test Plan:
- Cold miss then hit:
  - Stimulus: reset, then cpu_read=1, cpu_address=0x0000_0010, ROM word 4 = 0x00500093.
  - Required: stall_cpu=1 for 3 cycles; mem_read=1 with mem_address=0x10 in cycles 2-3; cycle 4 cpu_ready=1, cpu_data=0x00500093.
  - A repeated fetch of 0x10 hits with zero stall.
- Controller stall:
  - Stimulus: during REQUEST hold mem_stall=1 for 2 cycles.
  - Required: state holds, mem_read stays 1, stall_cpu=1 throughout; penalty becomes 5 cycles; correct data is filled.
- Wrong data source:
  - Stimulus: in WAIT, present mem_data_source=`DATA_SOURCE_RAM with mem_data=0xDEADBEEF for 1 cycle, then ROM with 0x00000013.
  - Required: line holds 0x00000013; 0xDEADBEEF is never returned.
- Conflict eviction:
  - Stimulus: NUM_LINES=16; fetch 0x04, then 0x44 (same index 1), then 0x04 again.
  - Required: the third access misses and refills with ROM word 1.
- Flush:
  - Stimulus: fill 0x08, assert flush 1 cycle, re-fetch 0x08.
  - Required: the re-fetch misses.
  - Variant: flush asserted in WAIT returns to IDLE with no line written; the next cycle re-misses.
- Reset mid-miss:
  - Stimulus: assert reset in WAIT.
  - Required: next cycle mem_read=0, stall_cpu=0, all lines invalid; a prior hit address now misses.
